gray_ptr_ctrl: RTL
==================

// Module: gray_ptr_ctrl
// PURPOSE
//  Parametrised FIFO pointer controller for one clock domain of an async FIFO.
//  - Keeps a local binary/Gray pointer and synchronises the remote Gray pointer.
//  - Converts the remote pointer back to binary and produces full/empty, almost and level.
//  - SIDE selects write-side (full) or read-side (empty) behaviour; instantiate one per domain.
// PARAMETERS
//  DLY          1  delay on every registered assignment
//  ADDR_WIDTH   4  RAM address width; DEPTH=2**ADDR_WIDTH; pointer width P=ADDR_WIDTH+1; >=1
//  SYNC_STAGES  2  flop stages on remote pointer; >=2
//  SIDE         0  0: write side (flag=full); 1: read side (flag=empty)
//  ALMOST_LVL   2  almost threshold; 0 < ALMOST_LVL < DEPTH
// PORTS
//  clk_i          in   1           local domain clock
//  rstn_i         in   1           async active-low reset
//  inc_i          in   1           push (SIDE=0) / pop (SIDE=1) request
//  remote_gray_i  in   P           Gray pointer from the other domain (asynchronous)
//  addr_o         out  ADDR_WIDTH  RAM address = ptr_bin_o[ADDR_WIDTH-1:0]
//  ptr_bin_o      out  P           local binary pointer
//  ptr_gray_o     out  P           local Gray pointer, flop output, goes to other domain
//  flag_o         out  1           full (SIDE=0) / empty (SIDE=1)
//  almost_o       out  1           almost-full / almost-empty
//  level_o        out  P           SIDE=0: entries used; SIDE=1: entries available; 0..DEPTH
// BEHAVIOUR
//  Clock/reset: one clock clk_i; rstn_i is asynchronous, active-low.
//  Reset (async, immediate): ptr_bin_o=0, ptr_gray_o=0, sync chain=0, level_o=0.
//   - SIDE=0: flag_o=0, almost_o=0.  SIDE=1: flag_o=1, almost_o=1.
//  Accept: acc = inc_i & ~flag_o. inc_i while flag_o=1 is ignored; no pointer change.
//  Next pointer: bin_nx = ptr_bin_o + acc, mod 2**P; gray_nx = bin_nx ^ (bin_nx>>1).
//   - Both registered at the accepting edge.
//   - addr/bin/gray update 1 edge after acc; ptr_gray_o changes in exactly 1 bit per step.
//   - This includes the wrap 2**P-1 -> 0.
//  Sync: remote_gray_i passes through SYNC_STAGES flops to give rgray.
//   - rbin = gray2bin(rgray), combinational: rbin[i] = ^rgray[P-1:i].
//   - No logic between remote_gray_i and the first flop.
//  Flags: registered, computed from next-state values.
//   - SIDE=0: full_nx = (gray_nx == {~rgray[P-1:P-2], rgray[P-3:0]}).
//     For P=2 the compare is gray_nx == ~rgray.
//   - SIDE=1: empty_nx = (gray_nx == rgray).
//  Level: registered, modulo-2**P subtraction, never exceeds DEPTH.
//   - SIDE=0: lvl_nx = bin_nx - rbin.  SIDE=1: lvl_nx = rbin - bin_nx.
//  Almost: registered.
//   - SIDE=0: almost_nx = (lvl_nx >= DEPTH-ALMOST_LVL).
//   - SIDE=1: almost_nx = (lvl_nx <= ALMOST_LVL).
//  Latency:
//   - Local acc -> flag/level/almost valid after 1 edge. Write side cannot overrun.
//   - Remote change -> flag/level/almost after SYNC_STAGES+1 edges.
//   - Flags are pessimistic: full deasserts late, empty deasserts late.
//  Simultaneous events:
//   - Local acc and a synced remote update on the same edge are both used in the *_nx terms.
//   - Flag may clear and set again on consecutive edges; this is legal.
//  Reset mid-operation: everything returns to reset values at once.
//   - Reset both domains together; a one-side reset is not supported.
// TESTING (ADDR_WIDTH=2, P=3, SYNC_STAGES=2, ALMOST_LVL=1 unless noted)
//  1 SIDE=0, remote_gray_i=0, inc_i held 1 for 5 edges:
//     bin 1,2,3,4; gray 001,011,010,110; level 1..4; almost at level 3; full after edge 4.
//     5th inc ignored (bin stays 4).
//  2 SIDE=1, after reset flag_o=1: drive remote_gray_i=3'b011 (bin 2):
//     empty clears and level_o=2 on the 3rd edge.
//     Two incs -> level 1 (almost=1), then 0 with empty=1.
//  3 Wrap: SIDE=0 with remote tracking local-2, 20 accepted incs.
//     Every ptr_gray_o step has Hamming distance 1, including 100->000.
//     ptr_bin_o wraps 7->0; addr_o wraps 3->0.
//  4 Full release: from full (bin 4, remote 0) drive remote 001 at the same edge as inc_i=1.
//     inc is ignored; full clears after 3 edges.
//     The next inc is accepted and full reasserts 1 edge later.
//  5 Async reset: drop rstn_i mid-high-phase with bin=3.
//     Outputs go to reset values before the next clk_i edge.
//     No update while rstn_i=0; first edge after release behaves as after power-up.
//  6 Param sweep ADDR_WIDTH=1 and 5, SYNC_STAGES=3:
//     Fill to DEPTH and drain to 0 against a model.
//     Remote-to-flag latency is 4 edges.

Source files
------------

// File: rtl/gray_ptr_ctrl.sv
// gray_ptr_ctrl: one-domain pointer controller for an asynchronous FIFO.
// Keeps the local binary/Gray pointer, synchronises the remote Gray pointer,
// and derives a registered full (write side) or empty (read side) flag,
// an almost flag and a fill level from the next-state pointer values.
//
// Ports
//   clk_i          local domain clock
//   rstn_i         asynchronous active-low reset
//   inc_i          push (SIDE=0) / pop (SIDE=1) request
//   remote_gray_i  Gray pointer from the other clock domain (asynchronous)
//   addr_o         RAM address, low ADDR_WIDTH bits of the binary pointer
//   ptr_bin_o      local binary pointer
//   ptr_gray_o     local Gray pointer (flop output, crosses to the other domain)
//   flag_o         full (SIDE=0) / empty (SIDE=1)
//   almost_o       almost-full (SIDE=0) / almost-empty (SIDE=1)
//   level_o        SIDE=0: entries used; SIDE=1: entries available
module gray_ptr_ctrl #(
  parameter int DLY         = 1,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SIDE        = 0,
  parameter int ALMOST_LVL  = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH:0]   remote_gray_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH:0]   ptr_bin_o,
  output logic [ADDR_WIDTH:0]   ptr_gray_o,
  output logic                  flag_o,
  output logic                  almost_o,
  output logic [ADDR_WIDTH:0]   level_o
);

  localparam int unsigned P     = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam bit          RD_SIDE = (SIDE != 0);
  // Full pattern: remote Gray pointer with its two MSBs inverted (all bits when P=2)
  localparam logic [P-1:0] FULL_MASK = P'(3) << (P - 2);
  localparam logic [P-1:0] ALM_HI    = P'(DEPTH - ALMOST_LVL);
  localparam logic [P-1:0] ALM_LO    = P'(ALMOST_LVL);

  // DLY is accepted for drop-in compatibility with existing instantiations;
  // registers update without any modelled delay.
  if (DLY < 0 || ADDR_WIDTH < 1 || SYNC_STAGES < 2 || SIDE < 0 || SIDE > 1 ||
      ALMOST_LVL <= 0 || ALMOST_LVL >= (1 << ADDR_WIDTH)) begin : g_param_err
    $error("gray_ptr_ctrl: illegal parameter combination");
  end

  logic [P-1:0] r_bin;
  logic [P-1:0] r_gray;
  logic         r_flag;
  logic         r_almost;
  logic [P-1:0] r_level;
  logic [P-1:0] r_sync [SYNC_STAGES];

  logic         w_acc;
  logic [P-1:0] w_bin_nx;
  logic [P-1:0] w_gray_nx;
  logic [P-1:0] w_rgray;
  logic [P-1:0] w_rbin;
  logic [P-1:0] w_lvl_nx;
  logic         w_flag_nx;
  logic         w_almost_nx;

  // Next-state pointer, remote pointer decode and flag terms
  always_comb begin
    w_acc       = inc_i & ~r_flag;
    w_bin_nx    = r_bin + P'(w_acc);
    w_gray_nx   = w_bin_nx ^ (w_bin_nx >> 1);
    w_rgray     = r_sync[SYNC_STAGES-1];
    w_rbin      = '0;
    for (int i = 0; i < int'(P); i++) begin
      w_rbin[i] = ^(w_rgray >> i);
    end
    w_lvl_nx    = '0;
    w_flag_nx   = 1'b0;
    w_almost_nx = 1'b0;
    if (RD_SIDE) begin
      w_lvl_nx    = w_rbin - w_bin_nx;
      w_flag_nx   = (w_gray_nx == w_rgray);
      w_almost_nx = (w_lvl_nx <= ALM_LO);
    end else begin
      w_lvl_nx    = w_bin_nx - w_rbin;
      w_flag_nx   = (w_gray_nx == (w_rgray ^ FULL_MASK));
      w_almost_nx = (w_lvl_nx >= ALM_HI);
    end
  end

  // Remote pointer synchroniser; first stage samples the raw input directly
  always_ff @(posedge clk_i or negedge rstn_i) begin : p_sync
    if (!rstn_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= remote_gray_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Local pointer and status registers
  always_ff @(posedge clk_i or negedge rstn_i) begin : p_state
    if (!rstn_i) begin
      r_bin    <= '0;
      r_gray   <= '0;
      r_level  <= '0;
      r_flag   <= RD_SIDE;
      r_almost <= RD_SIDE;
    end else begin
      r_bin    <= w_bin_nx;
      r_gray   <= w_gray_nx;
      r_level  <= w_lvl_nx;
      r_flag   <= w_flag_nx;
      r_almost <= w_almost_nx;
    end
  end

  assign addr_o     = r_bin[ADDR_WIDTH-1:0];
  assign ptr_bin_o  = r_bin;
  assign ptr_gray_o = r_gray;
  assign flag_o     = r_flag;
  assign almost_o   = r_almost;
  assign level_o    = r_level;

endmodule
